// File: rtl/control_pkg.sv
// ---------------------------------------------------------------------------
// control_pkg
// Shared definitions for the microprogrammed control sequencer:
//   mode_e        - 3-bit next-address mode carried in each microword
//   state_e       - sequencer top-level states
//   FETCH_ADDR    - micro-address where every instruction begins
//   DISPATCH_BASE - base of the opcode dispatch table in the microstore
// ---------------------------------------------------------------------------
package control_pkg;

  typedef enum logic [2:0] {
    MODE_SEQ      = 3'd0,
    MODE_JUMP     = 3'd1,
    MODE_DISPATCH = 3'd2,
    MODE_BRZ      = 3'd3,
    MODE_WAIT     = 3'd4,
    MODE_END      = 3'd5,
    MODE_HALT     = 3'd6
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam int FETCH_ADDR    = 1;
  localparam int DISPATCH_BASE = 16;

endpackage

// File: rtl/control_rom.sv
// ---------------------------------------------------------------------------
// control_rom
// Combinational microstore. Each address yields one microword split into
// its control field, next-address mode and jump/branch target.
// Ports:
//   upc_i    [ADDR_W] - micro-address to look up
//   ctrl_o   [CTRL_W] - control word driven onto the datapath
//   mode_o   [3]      - next-address mode
//   target_o [ADDR_W] - target for JUMP / taken BRZ
// ---------------------------------------------------------------------------
module control_rom
  import control_pkg::*;
#(
  parameter int CTRL_W = 10,
  parameter int ADDR_W = 6
) (
  input  logic [ADDR_W-1:0] upc_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output mode_e             mode_o,
  output logic [ADDR_W-1:0] target_o
);

  // Microprogram image. Every address not listed (including the unused
  // dispatch slots 19..31) is a zero control word that ends the instruction.
  always_comb begin
    ctrl_o   = '0;
    mode_o   = MODE_END;
    target_o = '0;
    case (upc_i)
      ADDR_W'(1): begin
        ctrl_o = CTRL_W'(16'h010);
        mode_o = MODE_SEQ;
      end
      ADDR_W'(2): begin
        ctrl_o = CTRL_W'(16'h010);
        mode_o = MODE_DISPATCH;
      end
      ADDR_W'(16): begin
        mode_o   = MODE_JUMP;
        target_o = ADDR_W'(32);
      end
      ADDR_W'(17): begin
        mode_o   = MODE_JUMP;
        target_o = ADDR_W'(40);
      end
      ADDR_W'(18): begin
        mode_o = MODE_HALT;
      end
      ADDR_W'(32): begin
        ctrl_o = CTRL_W'(16'h108);
        mode_o = MODE_SEQ;
      end
      ADDR_W'(33): begin
        ctrl_o = CTRL_W'(16'h064);
        mode_o = MODE_WAIT;
      end
      ADDR_W'(40): begin
        ctrl_o   = CTRL_W'(16'h200);
        mode_o   = MODE_BRZ;
        target_o = ADDR_W'(42);
      end
      ADDR_W'(41): begin
        ctrl_o = CTRL_W'(16'h001);
      end
      ADDR_W'(42): begin
        ctrl_o = CTRL_W'(16'h002);
      end
      default: begin
        ctrl_o   = '0;
        mode_o   = MODE_END;
        target_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/control_seq.sv
// ---------------------------------------------------------------------------
// control_seq
// Microprogrammed control sequencer. A step divider paces the machine so
// that the micro-address and state advance once every CLK_DIV clk2 cycles.
// Ports:
//   clk2      - sole clock, rising edge
//   rst       - asynchronous active-high reset
//   start     - level request to begin an instruction (IDLE only)
//   opcode    - instruction opcode, used by DISPATCH
//   z_flag    - datapath zero flag, used by BRZ
//   mem_ready - memory handshake, used by WAIT
//   ctrlsig   - current control word (zero outside RUN)
//   upc       - current micro-address
//   busy      - high in RUN
//   done      - one-cycle pulse on returning to IDLE via END
//   halted    - high in HALT until reset
// ---------------------------------------------------------------------------
module control_seq
  import control_pkg::*;
#(
  parameter int CTRL_W  = 10,
  parameter int ADDR_W  = 6,
  parameter int OP_W    = 4,
  parameter int CLK_DIV = 1
) (
  input  logic              clk2,
  input  logic              rst,
  input  logic              start,
  input  logic [OP_W-1:0]   opcode,
  input  logic              z_flag,
  input  logic              mem_ready,
  output logic [CTRL_W-1:0] ctrlsig,
  output logic [ADDR_W-1:0] upc,
  output logic              busy,
  output logic              done,
  output logic              halted
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_e            stateQ, stateD;
  logic [ADDR_W-1:0] upcQ, upcD;
  logic              doneQ, doneD;
  logic [DIV_W-1:0]  divQ, divD;
  logic              tick;

  logic [CTRL_W-1:0] romCtrl;
  mode_e             romMode;
  logic [ADDR_W-1:0] romTarget;
  logic [ADDR_W-1:0] upcInc;
  logic [ADDR_W-1:0] dispatchAddr;

  control_rom #(
    .CTRL_W (CTRL_W),
    .ADDR_W (ADDR_W)
  ) uRom (
    .upc_i    (upcQ),
    .ctrl_o   (romCtrl),
    .mode_o   (romMode),
    .target_o (romTarget)
  );

  // Step divider: tick marks the last clk2 cycle of each micro-step.
  // With CLK_DIV=1 the counter is stuck at zero and tick is always high.
  assign tick = (divQ == DIV_W'(CLK_DIV - 1));
  assign divD = tick ? '0 : divQ + DIV_W'(1);

  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      divQ <= '0;
    end else begin
      divQ <= divD;
    end
  end

  // Address arithmetic wraps naturally at ADDR_W bits.
  assign upcInc       = upcQ + ADDR_W'(1);
  assign dispatchAddr = ADDR_W'(DISPATCH_BASE) + ADDR_W'(opcode);

  // State register, including the done pulse flag.
  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      stateQ <= ST_IDLE;
      upcQ   <= '0;
      doneQ  <= 1'b0;
    end else begin
      stateQ <= stateD;
      upcQ   <= upcD;
      doneQ  <= doneD;
    end
  end

  // Next-state logic. Nothing moves between ticks; done is raised only on
  // the tick that retires an instruction, so it lasts exactly one clk2 cycle.
  // Unused mode encodings fall into the default branch and act as END.
  always_comb begin
    stateD = stateQ;
    upcD   = upcQ;
    doneD  = 1'b0;
    if (tick) begin
      case (stateQ)
        ST_IDLE: begin
          if (start) begin
            stateD = ST_RUN;
            upcD   = ADDR_W'(FETCH_ADDR);
          end
        end
        ST_RUN: begin
          case (romMode)
            MODE_SEQ:      upcD = upcInc;
            MODE_JUMP:     upcD = romTarget;
            MODE_DISPATCH: upcD = dispatchAddr;
            MODE_BRZ:      upcD = z_flag ? romTarget : upcInc;
            MODE_WAIT:     upcD = mem_ready ? upcInc : upcQ;
            MODE_HALT:     stateD = ST_HALT;
            default: begin
              stateD = ST_IDLE;
              upcD   = '0;
              doneD  = 1'b1;
            end
          endcase
        end
        default: begin
          stateD = stateQ;
        end
      endcase
    end
  end

  // Outputs: the control word is decoded from the registered upc and is
  // forced to zero whenever the sequencer is not running.
  always_comb begin
    ctrlsig = (stateQ == ST_RUN) ? romCtrl : '0;
    upc     = upcQ;
    busy    = (stateQ == ST_RUN);
    halted  = (stateQ == ST_HALT);
    done    = doneQ;
  end

endmodule

// File: tb/tb_control_seq.sv
// ---------------------------------------------------------------------------
// tb_control_seq
// Drives two sequencers (CLK_DIV=1 and CLK_DIV=3) from the same inputs and
// checks them against a behavioural microprogram model, a table of expected
// ADD-instruction outputs, and hand-written corner-case sequences.
// ---------------------------------------------------------------------------
module tb_control_seq;

  localparam int M_SEQ = 0, M_JUMP = 1, M_DISP = 2, M_BRZ = 3;
  localparam int M_WAIT = 4, M_END = 5, M_HALT = 6;

  logic       clk2 = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic       zFlag = 1'b0;
  logic       memReady = 1'b1;

  logic [9:0] ctrl1, ctrl3;
  logic [5:0] upc1, upc3;
  logic       busy1, busy3, done1, done3, halt1, halt3;

  int nCompared = 0;
  int nMismatched = 0;

  // Microprogram as written in the requirements table.
  int romCtrl [64];
  int romMode [64];
  int romTgt  [64];

  // Model state: st 0=idle 1=run 2=halt.
  typedef struct {
    int st;
    int upc;
    int cnt;
    bit done;
  } mdl_t;

  mdl_t m1, m3;

  typedef struct {
    bit start;
    int opcode;
    bit z;
    bit mr;
    int expUpc;
    int expCtrl;
    bit expBusy;
    bit expDone;
    bit expHalted;
  } vec_t;

  vec_t addVec [8];
  int   holdCnt [64];

  always #5 clk2 = ~clk2;

  control_seq #(.CTRL_W(10), .ADDR_W(6), .OP_W(4), .CLK_DIV(1)) dut1 (
    .clk2      (clk2),
    .rst       (rst),
    .start     (start),
    .opcode    (opcode),
    .z_flag    (zFlag),
    .mem_ready (memReady),
    .ctrlsig   (ctrl1),
    .upc       (upc1),
    .busy      (busy1),
    .done      (done1),
    .halted    (halt1)
  );

  control_seq #(.CTRL_W(10), .ADDR_W(6), .OP_W(4), .CLK_DIV(3)) dut3 (
    .clk2      (clk2),
    .rst       (rst),
    .start     (start),
    .opcode    (opcode),
    .z_flag    (zFlag),
    .mem_ready (memReady),
    .ctrlsig   (ctrl3),
    .upc       (upc3),
    .busy      (busy3),
    .done      (done3),
    .halted    (halt3)
  );

  // Behavioural model of one clk2 edge, following the mode rules directly.
  function automatic mdl_t mdlStep(mdl_t m, int div, bit r, bit s, int op, bit z, bit mr);
    mdl_t n;
    bit   tick;
    n = m;
    if (r) begin
      n = '{0, 0, 0, 1'b0};
      return n;
    end
    tick   = (m.cnt == div - 1);
    n.cnt  = tick ? 0 : m.cnt + 1;
    n.done = 1'b0;
    if (tick) begin
      if (m.st == 0) begin
        if (s) begin
          n.st  = 1;
          n.upc = 1;
        end
      end else if (m.st == 1) begin
        case (romMode[m.upc])
          M_SEQ:  n.upc = (m.upc + 1) % 64;
          M_JUMP: n.upc = romTgt[m.upc];
          M_DISP: n.upc = (16 + op) % 64;
          M_BRZ:  n.upc = z ? romTgt[m.upc] : (m.upc + 1) % 64;
          M_WAIT: n.upc = mr ? (m.upc + 1) % 64 : m.upc;
          M_HALT: n.st = 2;
          default: begin
            n.st   = 0;
            n.upc  = 0;
            n.done = 1'b1;
          end
        endcase
      end
    end
    return n;
  endfunction

  function automatic int mdlCtrl(mdl_t m);
    return (m.st == 1) ? romCtrl[m.upc] : 0;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    nCompared++;
    if (act != exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareModels();
    checkOutput("mdl1.upc", int'(upc1), m1.upc);
    checkOutput("mdl1.ctrl", int'(ctrl1), mdlCtrl(m1));
    checkOutput("mdl1.busy", int'(busy1), int'(m1.st == 1));
    checkOutput("mdl1.halted", int'(halt1), int'(m1.st == 2));
    checkOutput("mdl1.done", int'(done1), int'(m1.done));
    checkOutput("mdl3.upc", int'(upc3), m3.upc);
    checkOutput("mdl3.ctrl", int'(ctrl3), mdlCtrl(m3));
    checkOutput("mdl3.busy", int'(busy3), int'(m3.st == 1));
    checkOutput("mdl3.halted", int'(halt3), int'(m3.st == 2));
    checkOutput("mdl3.done", int'(done3), int'(m3.done));
  endtask

  // One clk2 cycle: inputs are already set, models advance on the edge and
  // the DUT outputs are compared 1 time unit later.
  task automatic applyStimulus(input bit s, input int op, input bit z, input bit mr);
    start    = s;
    opcode   = 4'(op);
    zFlag    = z;
    memReady = mr;
    @(posedge clk2);
    m1 = mdlStep(m1, 1, rst, start, int'(opcode), zFlag, memReady);
    m3 = mdlStep(m3, 3, rst, start, int'(opcode), zFlag, memReady);
    #1;
    compareModels();
  endtask

  // Asynchronous reset pulse asserted mid-cycle; outputs must clear at once.
  task automatic pulseReset();
    #1;
    rst = 1'b1;
    m1  = '{0, 0, 0, 1'b0};
    m3  = '{0, 0, 0, 1'b0};
    #1;
    checkOutput("rst.upc", int'(upc1), 0);
    checkOutput("rst.ctrl", int'(ctrl1), 0);
    checkOutput("rst.busy", int'(busy1), 0);
    checkOutput("rst.done", int'(done1), 0);
    checkOutput("rst.halted", int'(halt1), 0);
    checkOutput("rst.upc3", int'(upc3), 0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    #1;
    rst = 1'b0;
  endtask

  task automatic runAddTable(input string tag);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(addVec[i].start, addVec[i].opcode, addVec[i].z, addVec[i].mr);
      checkOutput({tag, ".upc"}, int'(upc1), addVec[i].expUpc);
      checkOutput({tag, ".ctrl"}, int'(ctrl1), addVec[i].expCtrl);
      checkOutput({tag, ".busy"}, int'(busy1), int'(addVec[i].expBusy));
      checkOutput({tag, ".done"}, int'(done1), int'(addVec[i].expDone));
      checkOutput({tag, ".halted"}, int'(halt1), int'(addVec[i].expHalted));
    end
  endtask

  initial begin
    for (int a = 0; a < 64; a++) begin
      romCtrl[a] = 0;
      romMode[a] = M_END;
      romTgt[a]  = 0;
    end
    romCtrl[1]  = 'h010; romMode[1]  = M_SEQ;
    romCtrl[2]  = 'h010; romMode[2]  = M_DISP;
    romMode[16] = M_JUMP; romTgt[16] = 32;
    romMode[17] = M_JUMP; romTgt[17] = 40;
    romMode[18] = M_HALT;
    romCtrl[32] = 'h108; romMode[32] = M_SEQ;
    romCtrl[33] = 'h064; romMode[33] = M_WAIT;
    romCtrl[40] = 'h200; romMode[40] = M_BRZ; romTgt[40] = 42;
    romCtrl[41] = 'h001;
    romCtrl[42] = 'h002;

    // ADD instruction at CLK_DIV=1, starting from IDLE.
    addVec[0] = '{1'b1, 0, 1'b0, 1'b1,  1, 'h010, 1'b1, 1'b0, 1'b0};
    addVec[1] = '{1'b0, 0, 1'b0, 1'b1,  2, 'h010, 1'b1, 1'b0, 1'b0};
    addVec[2] = '{1'b0, 0, 1'b0, 1'b1, 16, 'h000, 1'b1, 1'b0, 1'b0};
    addVec[3] = '{1'b0, 0, 1'b0, 1'b1, 32, 'h108, 1'b1, 1'b0, 1'b0};
    addVec[4] = '{1'b0, 0, 1'b0, 1'b1, 33, 'h064, 1'b1, 1'b0, 1'b0};
    addVec[5] = '{1'b0, 0, 1'b0, 1'b1, 34, 'h000, 1'b1, 1'b0, 1'b0};
    addVec[6] = '{1'b0, 0, 1'b0, 1'b1,  0, 'h000, 1'b0, 1'b1, 1'b0};
    addVec[7] = '{1'b0, 0, 1'b0, 1'b1,  0, 'h000, 1'b0, 1'b0, 1'b0};

    m1 = '{0, 0, 0, 1'b0};
    m3 = '{0, 0, 0, 1'b0};

    // Reset held with start high: nothing may move.
    $display("[TB] reset phase");
    #2;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 0, 1'b0, 1'b1);
      checkOutput("rstHold.busy", int'(busy1), 0);
      checkOutput("rstHold.upc", int'(upc1), 0);
      checkOutput("rstHold.busy3", int'(busy3), 0);
    end
    start = 1'b0;
    #1;
    rst = 1'b0;

    $display("[TB] ADD table");
    runAddTable("add");

    $display("[TB] WAIT stall");
    pulseReset();
    applyStimulus(1'b1, 0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 0, 1'b0, 1'b1);
    checkOutput("wait.reach", int'(upc1), 33);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 0, 1'b0, 1'b0);
      checkOutput("wait.holdUpc", int'(upc1), 33);
      checkOutput("wait.holdCtrl", int'(ctrl1), 'h064);
    end
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    checkOutput("wait.advance", int'(upc1), 34);
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    checkOutput("wait.done", int'(done1), 1);

    $display("[TB] BRZ taken / not taken");
    for (int zi = 1; zi >= 0; zi--) begin
      pulseReset();
      applyStimulus(1'b1, 1, 1'b0, 1'b1);
      applyStimulus(1'b0, 1, 1'b0, 1'b1);
      applyStimulus(1'b0, 1, 1'b0, 1'b1);
      checkOutput("brz.dispatch", int'(upc1), 17);
      applyStimulus(1'b0, 1, 1'b0, 1'b1);
      checkOutput("brz.ctrl40", int'(ctrl1), 'h200);
      applyStimulus(1'b0, 1, 1'(zi), 1'b1);
      checkOutput("brz.upc", int'(upc1), (zi == 1) ? 42 : 41);
      checkOutput("brz.ctrl", int'(ctrl1), (zi == 1) ? 'h002 : 'h001);
      applyStimulus(1'b0, 1, 1'b0, 1'b1);
      checkOutput("brz.done", int'(done1), 1);
    end

    $display("[TB] start held through END");
    pulseReset();
    applyStimulus(1'b1, 3, 1'b0, 1'b1);
    applyStimulus(1'b1, 3, 1'b0, 1'b1);
    applyStimulus(1'b1, 3, 1'b0, 1'b1);
    checkOutput("restart.slot19", int'(upc1), 19);
    applyStimulus(1'b1, 3, 1'b0, 1'b1);
    checkOutput("restart.done", int'(done1), 1);
    checkOutput("restart.idle", int'(busy1), 0);
    applyStimulus(1'b1, 3, 1'b0, 1'b1);
    checkOutput("restart.upc", int'(upc1), 1);
    checkOutput("restart.busy", int'(busy1), 1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 3, 1'b0, 1'b1);

    $display("[TB] HALT");
    pulseReset();
    applyStimulus(1'b1, 2, 1'b0, 1'b1);
    applyStimulus(1'b0, 2, 1'b0, 1'b1);
    applyStimulus(1'b0, 2, 1'b0, 1'b1);
    checkOutput("halt.slot18", int'(upc1), 18);
    applyStimulus(1'b0, 2, 1'b0, 1'b1);
    checkOutput("halt.halted", int'(halt1), 1);
    checkOutput("halt.ctrl", int'(ctrl1), 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 0, 1'b0, 1'b1);
      checkOutput("halt.ignoreStart", int'(halt1), 1);
      checkOutput("halt.notBusy", int'(busy1), 0);
    end
    pulseReset();
    checkOutput("halt.cleared", int'(halt1), 0);

    $display("[TB] CLK_DIV=3 pacing");
    pulseReset();
    for (int a = 0; a < 64; a++) holdCnt[a] = 0;
    for (int i = 0; i < 26; i++) begin
      applyStimulus(i < 4, 0, 1'b0, 1'b1);
      if (busy3) holdCnt[upc3]++;
    end
    checkOutput("pace.upc1", holdCnt[1], 3);
    checkOutput("pace.upc2", holdCnt[2], 3);
    checkOutput("pace.upc16", holdCnt[16], 3);
    checkOutput("pace.upc32", holdCnt[32], 3);
    checkOutput("pace.upc33", holdCnt[33], 3);
    checkOutput("pace.upc34", holdCnt[34], 3);

    $display("[TB] abort at upc 32");
    pulseReset();
    applyStimulus(1'b1, 0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0, 1'b0, 1'b1);
    checkOutput("abort.at32", int'(upc1), 32);
    pulseReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 0, 1'b0, 1'b1);
      checkOutput("abort.noDone", int'(done1), 0);
      checkOutput("abort.idleUpc", int'(upc1), 0);
    end
    runAddTable("rerun");

    $display("[TB] randomized run");
    pulseReset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        pulseReset();
      end else begin
        applyStimulus(1'($urandom_range(0, 2) != 0), int'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
